// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter and fetch sequencer. Holds the PC, advances it by one each
// run cycle, and applies taken branches using the target from the lookup
// stage. The target is either an absolute address or a signed two's-complement
// offset added to the current PC. All PC arithmetic wraps modulo 2**D. Also
// sequences program start/halt and counts cycles spent running.
//
// Parameters
//   D           PC / target width in bits
//   START_ADDR  PC loaded on reset and on every Start
//   CW          cycle-counter width
//
// Ports
//   Clk          in   1   clock, rising edge
//   Reset_n      in   1   asynchronous active-low reset
//   Start        in   1   pulse: begin program at START_ADDR (IDLE/HALTED only)
//   Stall        in   1   freeze PC this cycle
//   Branch       in   1   branch taken this cycle
//   Abs_jump     in   1   1 = Target is absolute, 0 = Target is a PC offset
//   Target       in   D   absolute address or signed offset
//   Halt_req     in   1   current instruction is the halt instruction
//   Prog_ctr     out  D   current PC (registered)
//   Fetch_valid  out  1   Prog_ctr is a live fetch this cycle
//   Done         out  1   program halted (registered)
//   Cycle_ct     out  CW  cycles spent in RUN, saturating
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int unsigned D          = 12,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CW         = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Branch,
  input  logic          Abs_jump,
  input  logic [D-1:0]  Target,
  input  logic          Halt_req,
  output logic [D-1:0]  Prog_ctr,
  output logic          Fetch_valid,
  output logic          Done,
  output logic [CW-1:0] Cycle_ct
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // PC-relative target: unsigned PC plus signed offset, wrapping mod 2**D.
  // Two's-complement addition at width D gives the wrap for free.
  function automatic logic [D-1:0] pc_rel(input logic [D-1:0] pc,
                                          input logic signed [D-1:0] ofs);
    return pc + $unsigned(ofs);
  endfunction

  // Sequential fall-through; 2**D-1 rolls over to 0.
  function automatic logic [D-1:0] pc_inc(input logic [D-1:0] pc);
    return pc + D'(1);
  endfunction

  // Run-cycle counter increment that sticks at all-ones.
  function automatic logic [CW-1:0] cyc_sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  state_t         state_p0, state_nxt;
  logic [D-1:0]   pc_p0,    pc_nxt;
  logic           done_p0,  done_nxt;
  logic [CW-1:0]  cyc_p0,   cyc_nxt;

  logic signed [D-1:0] offset;
  assign offset = $signed(Target);

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic. Everything holds unless a branch below
  // overrides it; Stall wins over Halt_req, which wins over Branch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    done_nxt  = done_p0;
    cyc_nxt   = cyc_p0;

    unique case (state_p0)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_RUN;
          pc_nxt    = START_PC;
          cyc_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end

      ST_RUN: begin
        // Stalled cycles are still run cycles, so the counter always moves.
        cyc_nxt = cyc_sat_inc(cyc_p0);
        if (!Stall) begin
          if (Halt_req) begin
            state_nxt = ST_HALTED;
            done_nxt  = 1'b1;
          end else if (Branch) begin
            pc_nxt = Abs_jump ? Target : pc_rel(pc_p0, offset);
          end else begin
            pc_nxt = pc_inc(pc_p0);
          end
        end
      end

      ST_HALTED: begin
        if (Start) begin
          state_nxt = ST_RUN;
          pc_nxt    = START_PC;
          cyc_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle state.
        state_nxt = ST_IDLE;
        pc_nxt    = START_PC;
        cyc_nxt   = '0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register (async reset takes effect immediately, mid-cycle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p0 <= ST_IDLE;
      pc_p0    <= START_PC;
      done_p0  <= 1'b0;
      cyc_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      done_p0  <= done_nxt;
      cyc_p0   <= cyc_nxt;
    end
  end

  assign Prog_ctr    = pc_p0;
  assign Done        = done_p0;
  assign Cycle_ct    = cyc_p0;
  assign Fetch_valid = (state_p0 == ST_RUN) && !Stall;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start, Stall, Branch, Abs_jump, Halt_req;
  logic [11:0] Target;

  logic [11:0] Prog_ctr, Prog_ctr4;
  logic        Fetch_valid, Fetch_valid4;
  logic        Done, Done4;
  logic [15:0] Cycle_ct;
  logic [3:0]  Cycle_ct4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_fetch_ctrl #(.D(12), .START_ADDR(0), .CW(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .Branch(Branch), .Abs_jump(Abs_jump), .Target(Target), .Halt_req(Halt_req),
    .Prog_ctr(Prog_ctr), .Fetch_valid(Fetch_valid), .Done(Done),
    .Cycle_ct(Cycle_ct)
  );

  // Narrow-counter copy driven by the same stimulus to exercise saturation.
  pc_fetch_ctrl #(.D(12), .START_ADDR(0), .CW(4)) dut_cw4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .Branch(Branch), .Abs_jump(Abs_jump), .Target(Target), .Halt_req(Halt_req),
    .Prog_ctr(Prog_ctr4), .Fetch_valid(Fetch_valid4), .Done(Done4),
    .Cycle_ct(Cycle_ct4)
  );

  typedef struct {
    logic        start, stall, branch, abs_j, halt;
    logic [11:0] target;
    logic        exp_fv;
    logic [11:0] exp_pc;
    logic        exp_done;
    logic [15:0] exp_cyc;
    logic [3:0]  exp_cyc4;
  } vec_t;

  typedef struct {
    logic [11:0] pc;
    logic        done;
    logic [15:0] cyc;
    logic [3:0]  cyc4;
  } exp_t;

  vec_t vt[$];
  exp_t sb_q[$];

  function automatic vec_t mk(bit st, bit sl, bit br, bit ab, bit hl,
                              logic [11:0] tg, bit fv, logic [11:0] pc,
                              bit dn, int cy);
    vec_t v;
    v.start = st; v.stall = sl; v.branch = br; v.abs_j = ab; v.halt = hl;
    v.target = tg; v.exp_fv = fv; v.exp_pc = pc; v.exp_done = dn;
    v.exp_cyc = 16'(cy);
    v.exp_cyc4 = (cy > 15) ? 4'd15 : 4'(cy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Start = 0; Stall = 0; Branch = 0; Abs_jump = 0; Halt_req = 0; Target = '0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    checks--;
    e = sb_q.pop_front();
    chk({tag, " pc"},       32'(Prog_ctr),  32'(e.pc));
    chk({tag, " done"},     32'(Done),      32'(e.done));
    chk({tag, " cyc"},      32'(Cycle_ct),  32'(e.cyc));
    chk({tag, " pc_cw4"},   32'(Prog_ctr4), 32'(e.pc));
    chk({tag, " cyc_cw4"},  32'(Cycle_ct4), 32'(e.cyc4));
  endtask

  // Called just after a falling edge: drive, check the combinational valid,
  // let one rising edge happen, then compare registered outputs.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    Start = v.start; Stall = v.stall; Branch = v.branch;
    Abs_jump = v.abs_j; Halt_req = v.halt; Target = v.target;
    e.pc = v.exp_pc; e.done = v.exp_done; e.cyc = v.exp_cyc; e.cyc4 = v.exp_cyc4;
    sb_q.push_back(e);
    #1;
    chk({tag, " fetch_valid"}, 32'(Fetch_valid), 32'(v.exp_fv));
    @(posedge Clk);
    @(negedge Clk);
    pop_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    Reset_n = 1'b0;

    //        st sl br ab hl target   fv pc      dn cyc
    vt.push_back(mk(0,0,0,0,0, 12'h000, 0, 12'd0,   0, 0));   // idle holds
    vt.push_back(mk(1,0,0,0,0, 12'h000, 0, 12'd0,   0, 0));   // start
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'd1,   0, 1));
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'd2,   0, 2));
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'd3,   0, 3));
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'd4,   0, 4));
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'd5,   0, 5));
    vt.push_back(mk(0,0,1,1,0, 12'd4,   1, 12'd4,   0, 6));   // abs to 4
    vt.push_back(mk(0,0,1,0,0, 12'hFFB, 1, 12'hFFF, 0, 7));   // 4 + (-5)
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'h000, 0, 8));   // wrap
    vt.push_back(mk(0,0,1,1,0, 12'd20,  1, 12'd20,  0, 9));
    vt.push_back(mk(0,0,1,1,0, 12'd346, 1, 12'd346, 0, 10));
    vt.push_back(mk(0,0,1,1,0, 12'd20,  1, 12'd20,  0, 11));
    vt.push_back(mk(0,1,1,1,0, 12'd346, 0, 12'd20,  0, 12));  // stall wins
    vt.push_back(mk(0,1,0,0,1, 12'h000, 0, 12'd20,  0, 13));  // stall beats halt
    vt.push_back(mk(0,0,1,0,0, 12'd5,   1, 12'd25,  0, 14));  // +5
    vt.push_back(mk(1,0,0,0,0, 12'h000, 1, 12'd26,  0, 15));  // start in RUN
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'd27,  0, 16));  // cw4 saturated
    vt.push_back(mk(0,0,1,1,0, 12'd9,   1, 12'd9,   0, 17));
    vt.push_back(mk(0,0,1,1,1, 12'd100, 1, 12'd9,   1, 18));  // halt beats branch
    vt.push_back(mk(0,0,1,1,0, 12'd100, 0, 12'd9,   1, 18));  // halted holds
    vt.push_back(mk(0,1,0,0,1, 12'h000, 0, 12'd9,   1, 18));
    vt.push_back(mk(1,0,0,0,0, 12'h000, 0, 12'd0,   0, 0));   // restart
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'd1,   0, 1));
    vt.push_back(mk(0,0,1,0,0, 12'h800, 1, 12'h801, 0, 2));   // 1 + (-2048)
    vt.push_back(mk(0,0,1,1,0, 12'hFFF, 1, 12'hFFF, 0, 3));
    vt.push_back(mk(0,0,0,0,0, 12'h000, 1, 12'h000, 0, 4));   // wrap

    // Reset state
    repeat (2) @(negedge Clk);
    chk("reset pc",          32'(Prog_ctr),    32'd0);
    chk("reset done",        32'(Done),        32'd0);
    chk("reset cyc",         32'(Cycle_ct),    32'd0);
    chk("reset fetch_valid", 32'(Fetch_valid), 32'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++)
      apply(vt[i], $sformatf("v%0d", i));

    // Async reset between edges while running at PC=77.
    apply(mk(0,0,1,1,0, 12'd77, 1, 12'd77, 0, 5), "jmp77");
    #2 Reset_n = 1'b0;
    #1;
    chk("async rst pc",          32'(Prog_ctr),    32'd0);
    chk("async rst done",        32'(Done),        32'd0);
    chk("async rst cyc",         32'(Cycle_ct),    32'd0);
    chk("async rst cyc_cw4",     32'(Cycle_ct4),   32'd0);
    chk("async rst fetch_valid", 32'(Fetch_valid), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(mk(0,0,0,0,0, 12'h000, 0, 12'd0, 0, 0), $sformatf("post_rst%0d", i));
    apply(mk(1,0,0,0,0, 12'h000, 0, 12'd0, 0, 0), "post_rst_start");
    apply(mk(0,0,0,0,0, 12'h000, 1, 12'd1, 0, 1), "post_rst_run");

    // Reset out of HALTED clears Done immediately.
    apply(mk(0,0,0,0,1, 12'h000, 1, 12'd1, 1, 2), "halt2");
    #3 Reset_n = 1'b0;
    #1;
    chk("halt rst done", 32'(Done),     32'd0);
    chk("halt rst pc",   32'(Prog_ctr), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    apply(mk(0,0,1,1,0, 12'd55, 0, 12'd0, 0, 0), "idle_ignores_branch");

    clear_inputs();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
